// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - opcode width and opcode constants (ADD..XOR; codes 6 and 7 are invalid)
//   - handshake FSM state encoding
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial-product
// step per clock.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   start           load operands a and b (ignored while not idle by caller)
//   a, b            WIDTH-bit unsigned operands
//   done            high during the cycle whose edge performs the last step
//   product         value the accumulator takes on that last step; the
//                   caller registers it on the edge where done is high
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // $clog2(WIDTH) bits always hold WIDTH-1 without wrapping for WIDTH >= 2.
  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] step_sum_s;
  logic               last_s;

  // Partial-product accumulation and last-step detection.
  always_comb begin
    step_sum_s = acc_r;
    if (mplier_r[0]) begin
      step_sum_s = acc_r + mcand_r;
    end else begin
      step_sum_s = acc_r;
    end
    last_s = busy_r && (cnt_r == CNT_W'(WIDTH - 1));
  end

  assign done    = last_s;
  assign product = step_sum_s;

  // Operand load on start, then one shift-add step per edge while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      cnt_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      acc_r    <= '0;
    end else if (busy_r) begin
      acc_r    <= step_sum_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      if (last_s) begin
        busy_r <= 1'b0;
        cnt_r  <= '0;
      end else begin
        busy_r <= 1'b1;
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// One operation in flight. ADD/SUB/AND/OR/XOR and invalid opcodes resolve on
// the accept edge; MUL runs WIDTH shift-add steps in alu_mul_seq.
// Ports:
//   clk, rst_n             clock / asynchronous active-low reset
//   in_valid, in_ready     operand handshake (in_ready high only in IDLE)
//   op, x, z               opcode and WIDTH-bit unsigned operands
//   out_valid, out_ready   result handshake (out_valid high only in DONE)
//   y                      2*WIDTH-bit result
//   out_err                invalid opcode flag, qualifies y
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               out_err
);

  state_e             state_r;
  state_e             state_d;
  logic [2*WIDTH-1:0] y_r;
  logic [2*WIDTH-1:0] y_d;
  logic               err_r;
  logic               err_d;
  logic [2*WIDTH-1:0] res_s;
  logic               res_err_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (x),
    .b       (z),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Single-cycle op decode. ADD/SUB use a WIDTH+1 bit result so bit WIDTH
  // is the carry, or for SUB the borrow (two's-complement wrap of x-z).
  always_comb begin
    res_s     = '0;
    res_err_s = 1'b0;
    case (op)
      OP_ADD: res_s = {{(WIDTH-1){1'b0}}, ({1'b0, x} + {1'b0, z})};
      OP_SUB: res_s = {{(WIDTH-1){1'b0}}, ({1'b0, x} - {1'b0, z})};
      OP_MUL: res_s = '0;
      OP_AND: res_s = {{WIDTH{1'b0}}, (x & z)};
      OP_OR:  res_s = {{WIDTH{1'b0}}, (x | z)};
      OP_XOR: res_s = {{WIDTH{1'b0}}, (x ^ z)};
      default: begin
        res_s     = '0;
        res_err_s = 1'b1;
      end
    endcase
  end

  // Handshake FSM next state and result-register load selection.
  always_comb begin
    state_d     = state_r;
    y_d         = y_r;
    err_d       = err_r;
    mul_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d     = ST_MUL;
            mul_start_s = 1'b1;
          end else begin
            state_d = ST_DONE;
            y_d     = res_s;
            err_d   = res_err_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_d = ST_DONE;
          y_d     = mul_prod_s;
          err_d   = 1'b0;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Result and error registers; held between loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r   <= '0;
      err_r <= 1'b0;
    end else begin
      y_r   <= y_d;
      err_r <= err_d;
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign y         = y_r;
  assign out_err   = err_r;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=8.
module tb_alu_mc;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   x;
  logic [W-1:0]   z;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
  logic           out_err;

  int n_cmp;
  int n_err;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op = o;
    x = a;
    z = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Consume the pending result and check return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle_vld"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Non-MUL op: result must be present right after the accept edge.
  task automatic one_cycle(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [15:0] ey, input logic ee);
    issue(o, a, b);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_y"}, {16'd0, y}, {16'd0, ey});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, ee});
    drain(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'd0;
    x = 8'd0;
    z = 8'd0;
    #12;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_y", {16'd0, y}, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    one_cycle("add", 3'd0, 8'd200, 8'd100, 16'h012C, 1'b0);
    one_cycle("add_ff", 3'd0, 8'd255, 8'd255, 16'h01FE, 1'b0);
    one_cycle("sub_borrow", 3'd1, 8'd5, 8'd7, 16'h01FE, 1'b0);
    one_cycle("sub", 3'd1, 8'd7, 8'd5, 16'h0002, 1'b0);
    one_cycle("and", 3'd3, 8'hAA, 8'h0F, 16'h000A, 1'b0);
    one_cycle("or", 3'd4, 8'hA0, 8'h05, 16'h00A5, 1'b0);
    one_cycle("inv6", 3'd6, 8'hAA, 8'h55, 16'h0000, 1'b1);
    one_cycle("xor", 3'd5, 8'hAA, 8'h55, 16'h00FF, 1'b0);
    one_cycle("inv7", 3'd7, 8'h12, 8'h34, 16'h0000, 1'b1);

    // MUL 255*255: W edges after accept, in_ready low, stray in_valid ignored.
    issue(3'd2, 8'd255, 8'd255);
    for (int i = 1; i < W; i++) begin
      chk("mul_busy_rdy", {31'd0, in_ready}, 32'd0);
      chk("mul_busy_vld", {31'd0, out_valid}, 32'd0);
      if (i == 3) begin
        in_valid = 1'b1;
        op = 3'd0;
        x = 8'd1;
        z = 8'd1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("mul_pre_vld", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mul_vld", {31'd0, out_valid}, 32'd1);
    chk("mul_y", {16'd0, y}, 32'h0000FE01);
    chk("mul_err", {31'd0, out_err}, 32'd0);
    chk("mul_rdy", {31'd0, in_ready}, 32'd0);
    drain("mul");

    // Backpressure on ADD 1+1, then no acceptance in the DONE->IDLE cycle.
    issue(3'd0, 8'd1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_vld", {31'd0, out_valid}, 32'd1);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_y", {16'd0, y}, 32'h00000002);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 3'd0;
    x = 8'd3;
    z = 8'd3;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_vld", {31'd0, out_valid}, 32'd0);
    chk("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
    chk("bp_hold_y", {16'd0, y}, 32'h00000002);
    tick();
    in_valid = 1'b0;
    chk("bp_next_vld", {31'd0, out_valid}, 32'd1);
    chk("bp_next_y", {16'd0, y}, 32'h00000006);
    drain("bp_next");

    // Reset after the 4th MUL iteration of 13*11.
    issue(3'd2, 8'd13, 8'd11);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rmul_vld", {31'd0, out_valid}, 32'd0);
    chk("rmul_y", {16'd0, y}, 32'd0);
    chk("rmul_err", {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rmul_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rmul_stay_vld", {31'd0, out_valid}, 32'd0);
    issue(3'd2, 8'd13, 8'd11);
    for (int i = 1; i < W; i++) begin
      tick();
    end
    chk("mul2_pre_vld", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mul2_vld", {31'd0, out_valid}, 32'd1);
    chk("mul2_y", {16'd0, y}, 32'h0000008F);
    drain("mul2");

    // Small MUL with zero operand.
    issue(3'd2, 8'd0, 8'd77);
    for (int i = 0; i < W; i++) begin
      tick();
    end
    chk("mul0_vld", {31'd0, out_valid}, 32'd1);
    chk("mul0_y", {16'd0, y}, 32'd0);
    drain("mul0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
